// File: rtl/tone_synth.sv
// rtl/tone_synth.sv - note-code to square-wave speaker driver with edge-aligned pitch changes (optional TONE_VOLUME_EN carrier gate)
module tone_synth #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int CNT_W    = 20,
    parameter int CAR_W    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] note,
    input  logic [2:0] vol,
    output logic       speaker,
    output logic [4:0] cur_note,
    output logic       active
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [4:0]       note_q;
    logic [4:0]       pending;
    logic [CNT_W-1:0] half_cur;
    logic [CNT_W-1:0] cnt;
    logic             wave;

    function automatic logic is_rest(input logic [4:0] code);
        return (code == 5'd0) || (code > 5'd21);
    endfunction

    function automatic logic [CNT_W-1:0] half_of(input logic [4:0] code);
        case (code)
            5'd1:    half_of = CNT_W'(CLK_FREQ / (2 * 131));
            5'd2:    half_of = CNT_W'(CLK_FREQ / (2 * 147));
            5'd3:    half_of = CNT_W'(CLK_FREQ / (2 * 165));
            5'd4:    half_of = CNT_W'(CLK_FREQ / (2 * 175));
            5'd5:    half_of = CNT_W'(CLK_FREQ / (2 * 196));
            5'd6:    half_of = CNT_W'(CLK_FREQ / (2 * 220));
            5'd7:    half_of = CNT_W'(CLK_FREQ / (2 * 247));
            5'd8:    half_of = CNT_W'(CLK_FREQ / (2 * 262));
            5'd9:    half_of = CNT_W'(CLK_FREQ / (2 * 294));
            5'd10:   half_of = CNT_W'(CLK_FREQ / (2 * 330));
            5'd11:   half_of = CNT_W'(CLK_FREQ / (2 * 349));
            5'd12:   half_of = CNT_W'(CLK_FREQ / (2 * 392));
            5'd13:   half_of = CNT_W'(CLK_FREQ / (2 * 440));
            5'd14:   half_of = CNT_W'(CLK_FREQ / (2 * 494));
            5'd15:   half_of = CNT_W'(CLK_FREQ / (2 * 523));
            5'd16:   half_of = CNT_W'(CLK_FREQ / (2 * 587));
            5'd17:   half_of = CNT_W'(CLK_FREQ / (2 * 659));
            5'd18:   half_of = CNT_W'(CLK_FREQ / (2 * 698));
            5'd19:   half_of = CNT_W'(CLK_FREQ / (2 * 784));
            5'd20:   half_of = CNT_W'(CLK_FREQ / (2 * 880));
            5'd21:   half_of = CNT_W'(CLK_FREQ / (2 * 988));
            default: half_of = '0;
        endcase
    endfunction

    logic             note_rest;
    logic             edge_hit;
    logic [4:0]       pend_next;
    logic [CNT_W-1:0] half_rom;

    assign note_rest = is_rest(note_q);
    assign half_rom  = half_of(note_q);
    assign edge_hit  = (cnt == half_cur - CNT_W'(1));
    // Last differing request wins; returning to the sounding note cancels it.
    assign pend_next = (note_q == cur_note) ? 5'd0 :
                       (note_q != pending)  ? note_q : pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            note_q   <= '0;
            pending  <= '0;
            half_cur <= '0;
            cnt      <= '0;
            wave     <= 1'b0;
            cur_note <= '0;
            active   <= 1'b0;
        end else begin
            note_q <= note;
            case (state)
                IDLE: begin
                    wave     <= 1'b0;
                    cnt      <= '0;
                    pending  <= '0;
                    cur_note <= '0;
                    active   <= 1'b0;
                    if (!note_rest) begin
                        cur_note <= note_q;
                        half_cur <= half_rom;
                        active   <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (note_rest) begin
                        wave     <= 1'b0;
                        cnt      <= '0;
                        pending  <= '0;
                        cur_note <= '0;
                        active   <= 1'b0;
                        state    <= IDLE;
                    end else if (edge_hit) begin
                        wave    <= ~wave;
                        cnt     <= '0;
                        pending <= '0;
                        if (pend_next != 5'd0) begin
                            cur_note <= pend_next;
                            half_cur <= half_of(pend_next);
                        end
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        pending <= pend_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TONE_VOLUME_EN
    logic [CAR_W-1:0] car_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) car_cnt <= '0;
        else        car_cnt <= car_cnt + CAR_W'(1);
    end

    assign speaker = wave & active & (32'(car_cnt) <= 32'(vol));
`else
    logic unused_vol;
    assign unused_vol = ^vol;
    assign speaker    = wave;
`endif

endmodule

// File: tb/tb_tone_synth.sv
// tb/tb_tone_synth.sv - randomized self-checking bench for tone_synth against an event-time reference model
module tb_tone_synth;
    localparam int CLK_FREQ = 8800;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] note  = '0;
    logic [2:0] vol   = '0;
    logic       speaker;
    logic [4:0] cur_note;
    logic       active;

    int checks = 0;
    int errors = 0;

    int freq [22] = '{0, 131, 147, 165, 175, 196, 220, 247,
                         262, 294, 330, 349, 392, 440, 494,
                         523, 587, 659, 698, 784, 880, 988};

    // Reference state: sounding note, wave level, absolute cycle of next toggle
    int m_snd  = 0;
    int m_wave = 0;
    int m_nq   = 0;
    int m_next = 0;
    int m_car  = 0;
    int cyc    = 0;

    tone_synth #(.CLK_FREQ(CLK_FREQ), .CNT_W(20), .CAR_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .note     (note),
        .vol      (vol),
        .speaker  (speaker),
        .cur_note (cur_note),
        .active   (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit is_rest(input int c);
        return (c == 0) || (c > 21);
    endfunction

    function automatic int half_of(input int c);
        return CLK_FREQ / (2 * freq[c]);
    endfunction

    task automatic model_reset();
        m_snd = 0; m_wave = 0; m_nq = 0; m_next = 0; m_car = 0;
    endtask

    task automatic model_step();
        cyc++;
        m_car = (m_car + 1) % 8;
        if (m_snd == 0) begin
            if (!is_rest(m_nq)) begin
                m_snd  = m_nq;
                m_wave = 0;
                m_next = cyc + half_of(m_nq);
            end
        end else if (is_rest(m_nq)) begin
            m_snd  = 0;
            m_wave = 0;
        end else if (cyc == m_next) begin
            m_wave ^= 1;
            m_snd  = m_nq;
            m_next = cyc + half_of(m_snd);
        end
        m_nq = int'(note);
    endtask

    task automatic compare(input string tag);
        int exp_spk;
        exp_spk = m_wave;
`ifdef TONE_VOLUME_EN
        exp_spk = (m_wave != 0 && m_car <= int'(vol)) ? 1 : 0;
`endif
        check({tag, " speaker"},  32'(speaker),  32'(exp_spk));
        check({tag, " active"},   32'(active),   32'(m_snd != 0));
        check({tag, " cur_note"}, 32'(cur_note), 32'(m_snd));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        if (rst_n) model_step();
        compare(tag);
    endtask

    task automatic hold(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset speaker", 32'(speaker), 0);
        check("reset active", 32'(active), 0);
        check("reset cur_note", 32'(cur_note), 0);
        rst_n = 1'b1;
        hold("idle", 3);

        // Steady A4 from idle: active rises two clocks after the note changes
        note = 5'd13;
        tick("start");
        check("start active lat1", 32'(active), 0);
        tick("start");
        check("start active lat2", 32'(active), 1);
        hold("steady", 45);

        // Pitch change mid half-period
        note = 5'd8;
        hold("pitch", 60);

        // Rapid retarget: 9 must never sound
        note = 5'd13;
        hold("back", 40);
        note = 5'd9;
        tick("retarget");
        check("retarget no9", 32'(cur_note == 5'd9), 0);
        note = 5'd15;
        for (int i = 0; i < 30; i++) begin
            tick("retarget");
            check("retarget no9", 32'(cur_note == 5'd9), 0);
        end

        // Rest codes 0, 22, 31 all mute immediately
        note = 5'd0;  hold("rest0", 5);
        note = 5'd13; hold("tone", 30);
        note = 5'd22; hold("rest22", 5);
        note = 5'd13; hold("tone", 30);
        note = 5'd31; hold("rest31", 5);

        // Asynchronous reset mid-tone
        note = 5'd13;
        hold("pre_reset", 25);
        rst_n = 1'b0;
        #1;
        check("async speaker", 32'(speaker), 0);
        check("async active", 32'(active), 0);
        check("async cur_note", 32'(cur_note), 0);
        model_reset();
        note = 5'd0;
        hold("in_reset", 2);
        rst_n = 1'b1;
        hold("post_reset", 10);

        // Volume levels
        note = 5'd13;
        vol  = 3'd1; hold("vol1", 40);
        vol  = 3'd7; hold("vol7", 40);
        vol  = 3'd0; hold("vol0", 40);

        // Random note sequences, including repeats, rests and short holds
        for (int s = 0; s < 250; s++) begin
            int pick;
            pick = int'($urandom_range(0, 9));
            if (pick < 2)       note = 5'($urandom_range(22, 31));
            else if (pick == 2) note = 5'd0;
            else if (pick == 3) note = note;
            else                note = 5'($urandom_range(1, 21));
            vol = 3'($urandom_range(0, 7));
            hold("rand", int'($urandom_range(0, 3)) == 0 ? int'($urandom_range(1, 3))
                                                        : int'($urandom_range(4, 40)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
